// File: rtl/inst_buffer_pkg.sv
// Shared constants and types for the fetch-to-decode instruction queue.
package inst_buffer_pkg;

  localparam logic [31:0]  NOP_INST   = 32'h0340_0000;
  localparam int unsigned  IBUF_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_mem.sv
// Queue storage: DEPTH x 64 array, synchronous write, asynchronous read.
module ibuf_mem
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IBUF_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  ibuf_entry_t       wdata,
  input  logic [PTR_W-1:0]  raddr,
  output ibuf_entry_t       rdata
);

  // No reset on purpose: contents are only observed while the entry is valid.
  ibuf_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_buffer.sv
// Instruction fetch queue between fetch and decode; circular FIFO with
// count-based full/empty, flush-on-redirect and NOP output when empty.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IBUF_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_ir,
  output logic             if_ready,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_ir,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  ibuf_entry_t wr_entry;
  ibuf_entry_t rd_entry;

  // Full/empty come from the registered count only, so if_ready has no
  // combinational dependence on id_ready.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    if_ready = !full && !flush;
    id_valid = !empty;
    push     = if_valid && if_ready;
    pop      = id_valid && id_ready && !flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    wr_entry    = '0;
    wr_entry.pc = if_pc;
    wr_entry.ir = if_ir;
  end

  ibuf_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Empty queue presents a defined NOP so decode never sees stale data.
  always_comb begin
    id_pc = 32'h0;
    id_ir = NOP_INST;
    if (id_valid) begin
      id_pc = rd_entry.pc;
      id_ir = rd_entry.ir;
    end
    count = count_q;
  end

endmodule
